// File: rtl/ibus_axi_bridge_pkg.sv
// Shared types for the instruction-bus responder and its AXI read master side.
package ibus_axi_bridge_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } bridge_state_t;

endpackage

// File: rtl/ibus_addr_translate.sv
// Combinational kseg0/kseg1 fold to a physical word address.
// Shared between the instruction and data bus bridges.
module ibus_addr_translate (
    input  logic [31:0] vaddr_i,
    output logic [31:0] paddr_o
);

    always_comb begin
        paddr_o = vaddr_i;
        if (vaddr_i[31:30] == 2'b10) begin
            paddr_o[31:29] = 3'b000;
        end
        paddr_o[1:0] = 2'b00;
    end

endmodule

// File: rtl/ibus_axi_bridge.sv
// Instruction-bus responder: one fetch in flight, each becomes a single-beat AXI read.
// addr_ok is combinational in IDLE; data_ok follows three cycles later at best.
module ibus_axi_bridge
    import ibus_axi_bridge_pkg::*;
#(
    parameter int unsigned      ID_W   = 4,
    parameter logic [ID_W-1:0]  AXI_ID = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  ibus_req_t       ireq,
    output ibus_resp_t      iresp,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic            bus_err
);

    bridge_state_t state_q, state_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic [31:0]   paddr;
    logic          unused_r_sideband;

    ibus_addr_translate u_addr_translate (
        .vaddr_i (ireq.addr),
        .paddr_o (paddr)
    );

    // Single-beat reads with a fixed ID: the response ID and last flag carry no information.
    assign unused_r_sideband = ^{rid, rlast};

    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    always_comb begin
        state_d       = state_q;
        araddr_d      = araddr_q;
        data_d        = data_q;
        err_d         = err_q;
        iresp.addr_ok = 1'b0;
        iresp.data_ok = 1'b0;
        iresp.data    = data_q;
        arvalid       = 1'b0;
        rready        = 1'b0;
        bus_err       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ireq.valid && !reset) begin
                    iresp.addr_ok = 1'b1;
                    araddr_d      = paddr;
                    state_d       = ST_AR;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d  = rdata;
                    err_d   = (rresp != AXI_RESP_OKAY);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                iresp.data_ok = 1'b1;
                bus_err       = err_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            araddr_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ibus_axi_bridge.sv
// Scoreboard bench: fetch driver and AXI slave model issue stimulus, a negedge monitor checks.
module tb_ibus_axi_bridge;
    import ibus_axi_bridge_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready, bus_err;

    ibus_axi_bridge dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .bus_err(bus_err)
    );

    initial forever #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0, acc_cnt = 0, dok_cnt = 0, drops = 0;
    int acc_cyc[$], dok_cyc[$];
    logic [31:0] acc_paddr[$], ar_q[$];
    exp_t resp_q[$];
    exp_t e;
    logic [31:0] p, last_data = '0, last_dok_data = '0;
    logic last_dok_err = 1'b0;
    logic outstanding = 1'b0, r_phase = 1'b0, exp_dok = 1'b0, rst_seen = 1'b0;

    int ar_fixed = 0, r_fixed = 0, err_pct = 0, force_n = 0;
    logic [31:0] force_data = '0;
    logic [1:0]  force_resp = '0;
    int ar_wait = 0, r_wait = 0;
    logic r_pend = 1'b0, s_rst, s_arv, s_arhs, s_rhs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference address map: both 512 MB windows at 0x8000_0000 and 0xA000_0000 alias physical 0.
    function automatic logic [31:0] xlate(input logic [31:0] a);
        logic [31:0] r;
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) r = a % 32'h2000_0000;
        else r = a;
        return r - (r % 4);
    endfunction

    function automatic int pick(input int f);
        return (f >= 0) ? f : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 3))
            0: a[31:29] = 3'b100;
            1: a[31:29] = 3'b101;
            2: a[31:30] = 2'b00;
            default: ;
        endcase
        return a;
    endfunction

    initial forever begin
        @(posedge clk);
        rst_seen = reset;
    end

    // AXI slave model
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
        forever begin
            @(negedge clk);
            s_rst = reset; s_arv = arvalid; s_arhs = arvalid && arready; s_rhs = rvalid && rready;
            @(posedge clk); #1;
            if (s_rst) begin
                r_pend = 1'b0; rvalid = 1'b0; rlast = 1'b0;
            end
            if (s_rst || !s_arv) begin
                ar_wait = pick(ar_fixed); arready = (ar_wait == 0);
            end else if (s_arhs) begin
                ar_wait = pick(ar_fixed); arready = (ar_wait == 0);
                r_pend = 1'b1; r_wait = pick(r_fixed);
            end else if (!arready) begin
                if (ar_wait <= 1) begin arready = 1'b1; ar_wait = 0; end
                else ar_wait--;
            end
            if (!s_rst) begin
                if (s_rhs) begin rvalid = 1'b0; rlast = 1'b0; r_pend = 1'b0; end
                if (r_pend && !rvalid) begin
                    if (r_wait == 0) begin
                        rvalid = 1'b1; rlast = 1'b1; rid = 4'($urandom);
                        if (force_n > 0) begin
                            rdata = force_data; rresp = force_resp; force_n--;
                        end else begin
                            rdata = $urandom;
                            rresp = (int'($urandom_range(0, 99)) < err_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
                        end
                    end else r_wait--;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_seen) begin
            chk("reset_ctrl", 32'({arvalid, rready, iresp.addr_ok, iresp.data_ok, bus_err}), 32'd0);
            chk("reset_araddr", araddr, 32'd0);
            chk("reset_data", iresp.data, 32'd0);
            if (outstanding) drops++;
            ar_q.delete(); resp_q.delete();
            outstanding = 1'b0; r_phase = 1'b0; exp_dok = 1'b0; last_data = '0;
        end else begin
            chk("addr_ok", 32'(iresp.addr_ok), 32'(ireq.valid && !outstanding && !reset));
            chk("arvalid", 32'(arvalid), 32'(ar_q.size() != 0));
            chk("rready", 32'(rready), 32'(r_phase));
            chk("data_ok", 32'(iresp.data_ok), 32'(exp_dok));
            if (iresp.data_ok) begin
                if (resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    chk("resp_data", iresp.data, e.data);
                    chk("resp_bus_err", 32'(bus_err), 32'(e.err));
                    last_data = e.data;
                end
                outstanding = 1'b0; dok_cnt++; dok_cyc.push_back(cyc);
                last_dok_data = iresp.data; last_dok_err = bus_err;
            end else begin
                chk("bus_err_idle", 32'(bus_err), 32'd0);
                chk("data_hold", iresp.data, last_data);
            end
            exp_dok = 1'b0;
            if (arvalid && ar_q.size() != 0) begin
                chk("araddr", araddr, ar_q[0]);
                chk("ar_fields", 32'({arid, arlen, arsize, arburst}), 32'({4'd0, 8'd0, 3'b010, 2'b01}));
                if (arready) begin void'(ar_q.pop_front()); r_phase = 1'b1; end
            end else if (rvalid && rready && r_phase) begin
                resp_q.push_back({rdata, rresp != 2'b00});
                r_phase = 1'b0; exp_dok = 1'b1;
            end
            if (iresp.addr_ok) begin
                p = xlate(ireq.addr);
                ar_q.push_back(p); acc_paddr.push_back(p);
                outstanding = 1'b1; acc_cnt++; acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_acc(input int target, input string nm);
        for (int n = 0; n < 300 && acc_cnt < target; n++) begin @(negedge clk); #1; end
        chk(nm, 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic wait_dok(input int target, input string nm);
        for (int n = 0; n < 300 && dok_cnt < target; n++) begin @(negedge clk); #1; end
        chk(nm, 32'(dok_cnt >= target), 32'd1);
    endtask

    task automatic fetch_one(input logic [31:0] a, output int lat);
        int a0, d0;
        a0 = acc_cnt; d0 = dok_cnt;
        @(posedge clk); #1; ireq.valid = 1'b1; ireq.addr = a;
        wait_acc(a0 + 1, "accept_timeout");
        @(posedge clk); #1; ireq.valid = 1'b0;
        wait_dok(d0 + 1, "data_ok_timeout");
        lat = (acc_cnt > a0 && dok_cnt > d0) ? dok_cyc[d0] - acc_cyc[a0] : -1;
    endtask

    initial begin
        int lat, a0, d0, sent;
        reset = 1'b1; ireq = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        a0 = acc_cnt;
        fetch_one(32'hbfc0_0000, lat);
        chk("boot_latency", 32'(lat), 32'd3);
        if (acc_paddr.size() > a0) chk("boot_paddr", acc_paddr[a0], 32'h1fc0_0000);

        ar_fixed = 5;
        fetch_one(32'h9fc0_0104, lat);
        chk("ar_backpressure_latency", 32'(lat), 32'd8);
        ar_fixed = 0;

        force_n = 1; force_data = 32'hdead_beef; force_resp = 2'b10;
        fetch_one(32'h0040_0008, lat);
        chk("err_data", last_dok_data, 32'hdead_beef);
        chk("err_flag", 32'(last_dok_err), 32'd1);
        chk("err_latency", 32'(lat), 32'd3);

        r_fixed = 3; a0 = acc_cnt; d0 = dok_cnt;
        @(posedge clk); #1; ireq.valid = 1'b1; ireq.addr = 32'hbfc0_0010;
        wait_acc(a0 + 1, "flush_accept");
        for (int n = 0; n < 50 && !r_phase; n++) begin @(negedge clk); #1; end
        chk("flush_reach_r", 32'(r_phase), 32'd1);
        @(posedge clk); #1; ireq.addr = 32'h8000_1000;
        wait_acc(a0 + 2, "flush_new_accept");
        @(posedge clk); #1; ireq.valid = 1'b0;
        wait_dok(d0 + 2, "flush_data_ok");
        chk("flush_dok_count", 32'(dok_cnt - d0), 32'd2);
        if (acc_paddr.size() > a0 + 1 && dok_cyc.size() > d0) begin
            chk("flush_old_paddr", acc_paddr[a0], 32'h1fc0_0010);
            chk("flush_new_paddr", acc_paddr[a0 + 1], 32'h0000_1000);
            chk("flush_order", 32'(dok_cyc[d0] < acc_cyc[a0 + 1]), 32'd1);
        end

        r_fixed = 10; d0 = dok_cnt;
        @(posedge clk); #1; ireq.valid = 1'b1; ireq.addr = 32'hbfc0_0020;
        wait_acc(acc_cnt + 1, "rst_accept");
        @(posedge clk); #1; ireq.valid = 1'b0;
        for (int n = 0; n < 50 && !r_phase; n++) begin @(negedge clk); #1; end
        chk("rst_reach_r", 32'(r_phase), 32'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        repeat (12) @(posedge clk);
        chk("rst_no_data_ok", 32'(dok_cnt - d0), 32'd0);
        r_fixed = 0;
        fetch_one(32'h0040_0000, lat);
        chk("rst_restart_latency", 32'(lat), 32'd3);

        a0 = acc_cnt; d0 = dok_cnt; sent = 0;
        @(posedge clk); #1; ireq.valid = 1'b1; ireq.addr = 32'h8000_2000;
        for (int n = 0; n < 200 && sent < 8; n++) begin
            @(negedge clk); #1;
            if (acc_cnt - a0 > sent) begin
                sent = acc_cnt - a0;
                @(posedge clk); #1;
                if (sent < 8) ireq.addr = ireq.addr + 32'd4;
                else ireq.valid = 1'b0;
            end
        end
        ireq.valid = 1'b0;
        wait_dok(d0 + 8, "stream_data_ok");
        chk("stream_acc_count", 32'(acc_cnt - a0), 32'd8);
        chk("stream_dok_count", 32'(dok_cnt - d0), 32'd8);
        if (acc_cyc.size() >= a0 + 8)
            for (int i = 1; i < 8; i++) chk("stream_spacing", 32'(acc_cyc[a0 + i] - acc_cyc[a0 + i - 1]), 32'd4);
        if (acc_paddr.size() >= a0 + 8) chk("stream_last_paddr", acc_paddr[a0 + 7], 32'h0000_201c);

        ar_fixed = -1; r_fixed = -1; err_pct = 25;
        repeat (600) begin
            int r;
            @(posedge clk); #1;
            r = int'($urandom_range(0, 99));
            if (r < 15) ireq.valid = ~ireq.valid;
            if (r >= 60) ireq.addr = rand_addr();
        end
        ireq.valid = 1'b0;
        for (int n = 0; n < 100 && outstanding; n++) begin @(negedge clk); #1; end
        chk("drain", 32'(outstanding), 32'd0);
        chk("commitment", 32'(acc_cnt), 32'(dok_cnt + drops));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
